// File: rtl/fp_norm_sequencer.sv
`default_nettype none
// ============================================================================
// fp_norm_sequencer : handshaked one-bit-per-clock normalizer for the FP adder
// Revision: 1.0
// ============================================================================
module fp_norm_sequencer #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 24,
   parameter int SHC_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sign,
   input  logic               in_carry,
   input  logic [EXP_W-1:0]   in_exponent,
   input  logic [MAN_W:0]     in_mantissa,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sign,
   output logic [EXP_W-1:0]   out_exponent,
   output logic [MAN_W-1:0]   out_mantissa,
   output logic [SHC_W-1:0]   out_shifts,
   output logic               out_zero,
   output logic               out_underflow,
   output logic               out_overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [EXP_W-1:0] EXP_ONE    = EXP_W'(1);
   localparam logic [EXP_W-1:0] EXP_ONES   = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] EXP_OVF_TH = {{(EXP_W-1){1'b1}}, 1'b0};
   localparam logic [SHC_W-1:0] SHC_ONE    = SHC_W'(1);

   state_t             state_q;
   logic               sign_q;
   logic [EXP_W-1:0]   exp_q;
   logic [MAN_W-1:0]   man_q;
   logic [SHC_W-1:0]   shc_q;
   logic               zero_q;
   logic               unf_q;
   logic               ovf_q;

   logic [EXP_W-1:0]   exp_inc_d;
   logic [EXP_W-1:0]   exp_dec_d;
   logic [MAN_W-1:0]   man_rsh_d;
   logic [MAN_W-1:0]   man_lsh_d;
   logic [SHC_W-1:0]   shc_inc_d;
   logic               accept;

   assign exp_inc_d = in_exponent + EXP_ONE;
   assign exp_dec_d = exp_q - EXP_ONE;
   assign man_rsh_d = in_mantissa[MAN_W:1];
   assign man_lsh_d = {man_q[MAN_W-2:0], 1'b0};
   assign shc_inc_d = shc_q + SHC_ONE;
   assign accept    = in_valid && (state_q == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         man_q   <= '0;
         shc_q   <= '0;
         zero_q  <= 1'b0;
         unf_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  sign_q <= in_sign;
                  shc_q  <= '0;
                  zero_q <= 1'b0;
                  unf_q  <= 1'b0;
                  ovf_q  <= 1'b0;
                  state_q <= S_DONE;
                  if (in_carry) begin
                     // Saturate instead of letting exponent+1 reach or wrap past all-ones.
                     if (in_exponent >= EXP_OVF_TH) begin
                        exp_q <= EXP_ONES;
                        man_q <= '0;
                        ovf_q <= 1'b1;
                     end else begin
                        exp_q <= exp_inc_d;
                        man_q <= man_rsh_d;
                     end
                  end else if (in_mantissa == '0) begin
                     exp_q  <= '0;
                     man_q  <= '0;
                     zero_q <= 1'b1;
                  end else if (in_mantissa[MAN_W-1]) begin
                     exp_q <= in_exponent;
                     man_q <= in_mantissa[MAN_W-1:0];
                  end else if (in_exponent <= EXP_ONE) begin
                     exp_q <= '0;
                     man_q <= in_mantissa[MAN_W-1:0];
                     unf_q <= 1'b1;
                  end else begin
                     exp_q   <= in_exponent;
                     man_q   <= in_mantissa[MAN_W-1:0];
                     state_q <= S_SHIFT;
                  end
               end
            end

            S_SHIFT: begin
               // Exponent 1 cannot absorb another shift: leave a denormal.
               if (exp_q == EXP_ONE) begin
                  exp_q   <= '0;
                  unf_q   <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  man_q <= man_lsh_d;
                  exp_q <= exp_dec_d;
                  shc_q <= shc_inc_d;
                  if (man_q[MAN_W-2]) begin
                     state_q <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  state_q <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready      = (state_q == S_IDLE);
   assign out_valid     = (state_q == S_DONE);
   assign out_sign      = sign_q;
   assign out_exponent  = exp_q;
   assign out_mantissa  = man_q;
   assign out_shifts    = shc_q;
   assign out_zero      = zero_q;
   assign out_underflow = unf_q;
   assign out_overflow  = ovf_q;

endmodule
`default_nettype wire
